bin_to_dec_ascii: RTL and testbench

Sequential binary-to-decimal-ASCII formatter that sits directly downstream of the radix converter (`OtherSystemToDecimal`). It accepts the converter's 32-bit result over a valid/ready handshake and converts it to BCD with a shift-add-3 (double-dabble) engine, one bit per cycle. It then streams the decimal digits out as ASCII characters, most significant first, with leading zeros suppressed. Its output stream feeds the display/UART path.

---
 rtl/bin_to_dec_pkg.sv | 26 ++
 rtl/bin_to_dec_ascii_digit_adj.sv | 7 +
 rtl/bin_to_dec_ascii.sv | 161 ++++++++++++++++
 tb/tb_bin_to_dec_ascii.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bin_to_dec_pkg.sv
// Shared types and constants for the binary-to-decimal-ASCII formatter.
// BIN_TO_DEC_SIGNED_EN adds the SIGN state for two's-complement input.
package bin_to_dec_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_DIGITS = 10;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_SCAN,
`ifdef BIN_TO_DEC_SIGNED_EN
        ST_SIGN,
`endif
        ST_EMIT
    } state_t;

    // ceil(width * log10(2)), in fixed point so it works at elaboration
    function automatic int min_digits(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bin_to_dec_ascii_digit_adj.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3, no carry out.
module bcd_digit_adj (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bin_to_dec_ascii.sv
// Binary to decimal ASCII streamer: serial double-dabble, then MSD-first digits, no leading zeros.
// Define BIN_TO_DEC_SIGNED_EN for two's-complement input with a leading '-' on negatives.
module bin_to_dec_ascii
    import bin_to_dec_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DIGITS = DEFAULT_DIGITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_char,
    output logic             out_last,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;

    generate
        if (DIGITS < min_digits(WIDTH)) begin : g_digits_chk
            $error("bin_to_dec_ascii: DIGITS too small to hold WIDTH-bit values");
        end
    endgenerate

    state_t                 state;
    logic [WIDTH-1:0]       shreg;
    logic [WIDTH-1:0]       mag;
    logic [DIGITS-1:0][3:0] bcd;
    logic [DIGITS-1:0][3:0] bcd_adj;
    logic [CNT_W-1:0]       cnt;
    logic [PTR_W-1:0]       ptr;
    logic [PTR_W-1:0]       ptr_dec;
    logic [PTR_W-1:0]       msd;
    logic [DIGITS*4+WIDTH-1:0] shifted;
`ifdef BIN_TO_DEC_SIGNED_EN
    logic                   neg;
`endif

    function automatic logic [7:0] ascii(input logic [3:0] d);
        return ASCII_ZERO + {4'b0000, d};
    endfunction

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .d (bcd[g]),
                .q (bcd_adj[g])
            );
        end
    endgenerate

    assign shifted = {bcd_adj, shreg} << 1;

`ifdef BIN_TO_DEC_SIGNED_EN
    // -2^(WIDTH-1) negates to itself, which is already the right unsigned magnitude
    assign mag = in_data[WIDTH-1] ? -in_data : in_data;
`else
    assign mag = in_data;
`endif

    // Highest non-zero digit wins; an all-zero value leaves msd at 0 so one '0' goes out
    always_comb begin
        msd = '0;
        for (int i = 0; i < DIGITS; i++)
            if (bcd[i] != 4'd0)
                msd = PTR_W'(i);
    end

    assign ptr_dec  = ptr - PTR_ONE;
    assign in_ready = (state == ST_IDLE) && !rst;
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            bcd       <= '0;
            cnt       <= '0;
            ptr       <= '0;
            out_valid <= 1'b0;
            out_char  <= 8'h00;
            out_last  <= 1'b0;
`ifdef BIN_TO_DEC_SIGNED_EN
            neg       <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        shreg <= mag;
                        bcd   <= '0;
                        cnt   <= CNT_INIT;
`ifdef BIN_TO_DEC_SIGNED_EN
                        neg   <= in_data[WIDTH-1];
`endif
                        state <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    {bcd, shreg} <= shifted;
                    cnt          <= cnt - CNT_ONE;
                    if (cnt == '0)
                        state <= ST_SCAN;
                end
                ST_SCAN: begin
                    ptr       <= msd;
                    out_valid <= 1'b1;
`ifdef BIN_TO_DEC_SIGNED_EN
                    if (neg) begin
                        out_char <= ASCII_MINUS;
                        out_last <= 1'b0;
                        state    <= ST_SIGN;
                    end else begin
                        out_char <= ascii(bcd[msd]);
                        out_last <= (msd == '0);
                        state    <= ST_EMIT;
                    end
`else
                    out_char  <= ascii(bcd[msd]);
                    out_last  <= (msd == '0);
                    state     <= ST_EMIT;
`endif
                end
`ifdef BIN_TO_DEC_SIGNED_EN
                ST_SIGN: begin
                    if (out_ready) begin
                        out_char <= ascii(bcd[ptr]);
                        out_last <= (ptr == '0);
                        state    <= ST_EMIT;
                    end
                end
`endif
                ST_EMIT: begin
                    if (out_ready) begin
                        if (ptr == '0) begin
                            out_valid <= 1'b0;
                            out_char  <= 8'h00;
                            out_last  <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            ptr      <= ptr_dec;
                            out_char <= ascii(bcd[ptr_dec]);
                            out_last <= (ptr_dec == '0);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_dec_ascii.sv
// Scoreboard bench for bin_to_dec_ascii: directed values, expected chars queued at issue,
// a negedge monitor pops and compares on every output handshake and watches stall stability.
module tb_bin_to_dec_ascii;

    localparam int WIDTH = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_char;
    logic        out_last;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int ready_mode = 0;
    logic [8:0] expq[$];

    always #5 clk = ~clk;

    bin_to_dec_ascii #(.WIDTH(32), .DIGITS(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_char  (out_char),
        .out_last  (out_last),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_str(input string s);
        logic [8:0] e;
        for (int i = 0; i < s.len(); i++) begin
            e = {s[i], (i == s.len() - 1)};
            expq.push_back(e);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] v);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            tick;
            n++;
        end
        if (!in_ready)
            check("send_in_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = v;
        tick;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((expq.size() != 0 || busy) && n < 300) begin
            tick;
            n++;
        end
        check({name, "_done"}, {31'b0, (n < 300)}, 32'd1);
    endtask

    // out_ready: 0 = always high, 1 = pattern 1,0,0 repeating, 2 = held low
    initial begin
        int ph;
        ph = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = (ph == 0);
                    ph = (ph + 1) % 3;
                end
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        logic       stall;
        logic [8:0] held;
        logic [8:0] e;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (stall && out_valid)
                check("stall_hold", {23'b0, out_char, out_last}, {23'b0, held});
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_char: got %0h expected none", out_char);
                end else begin
                    e = expq.pop_front();
                    check("char", {23'b0, out_char, out_last}, {23'b0, e});
                end
            end
            stall = out_valid && !out_ready;
            held  = {out_char, out_last};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) tick;
        check("rst_in_ready",  {31'b0, in_ready},  32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_char",  {24'b0, out_char},  32'd0);
        check("rst_out_last",  {31'b0, out_last},  32'd0);
        check("rst_busy",      {31'b0, busy},      32'd0);
        rst = 1'b0;
        tick;
        check("release_in_ready", {31'b0, in_ready}, 32'd1);

        // first out_valid lands in cycle T+WIDTH+2, i.e. WIDTH+1 edges after the accept edge
        push_str("0");
        send(32'd0);
        n = 0;
        while (!out_valid && n < 100) begin
            tick;
            n++;
        end
        check("first_latency", n, WIDTH + 1);
        wait_done("zero");

        push_str("10");
        send(32'd10);
        wait_done("ten");

        ready_mode = 1;
        push_str("127");
        send(32'd127);
        wait_done("stall127");
        ready_mode = 0;

`ifdef BIN_TO_DEC_SIGNED_EN
        push_str("-1");
`else
        push_str("4294967295");
`endif
        send(32'hFFFF_FFFF);
        wait_done("all_ones");

`ifdef BIN_TO_DEC_SIGNED_EN
        push_str("-2147483648");
`else
        push_str("2147483648");
`endif
        send(32'h8000_0000);
        wait_done("msb_only");

        push_str("63");
        send(32'd63);
        repeat (5) tick;
        check("convert_in_ready", {31'b0, in_ready}, 32'd0);
        check("convert_busy",     {31'b0, busy},     32'd1);
        in_valid = 1'b1;
        in_data  = 32'd5;
        tick;
        in_valid = 1'b0;
        in_data  = '0;
        wait_done("ignore5");

        // abort 4095 after its first character: only '4' may ever appear
        expq.push_back({8'h34, 1'b0});
        send(32'd4095);
        n = 0;
        while (!out_valid && n < 100) begin
            tick;
            n++;
        end
        tick;
        ready_mode = 2;
        rst = 1'b1;
        tick;
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_in_ready",  {31'b0, in_ready},  32'd0);
        check("abort_busy",      {31'b0, busy},      32'd0);
        rst = 1'b0;
        ready_mode = 0;
        tick;
        check("abort_release_in_ready", {31'b0, in_ready}, 32'd1);
        check("abort_queue_empty", expq.size(), 32'd0);

        push_str("63");
        send(32'd63);
        wait_done("after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
